// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop walks the operands over
// WIDTH cycles; start/busy/done frame each operation and the published
// result only changes on completion or reset.
module serial_subtractor #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] r_sr_q;
   logic             br_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   logic             d_bit;
   logic             br_d;
   logic [WIDTH-1:0] r_sr_d;
   logic             last_bit;

   // Full-subtractor cell on the current LSBs and the partial result it feeds
   always_comb begin
      d_bit    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
      br_d     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
      r_sr_d   = {d_bit, r_sr_q[WIDTH-1:1]};
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Control FSM, datapath shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         r_sr_q   <= '0;
         br_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               br_q   <= br_d;
               r_sr_q <= r_sr_d;
               a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
               b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
               cnt_q  <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  diff_q   <= r_sr_d;
                  borrow_q <= br_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4 and WIDTH=8 instances).
// Expected {borrow,diff} values are queued when a start is driven and popped
// when the matching instance raises done.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       bin4 = 1'b0;
   logic       busy4, done4, borrow4;
   logic [3:0] diff4;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic       busy8, done8, borrow8;
   logic [7:0] diff8;

   int checks = 0;
   int errors = 0;

   logic [4:0] sb4[$];
   logic [8:0] sb8[$];
   logic [4:0] last4 = '0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
   );

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   // Scoreboard for the 4-bit instance: compare on every done pulse
   always @(negedge clk) begin
      if (done4) begin
         checks++;
         if (sb4.size() == 0) begin
            errors++;
            $display("FAIL sb4_unexpected_done got=%b_%b expected=no_done", borrow4, diff4);
         end else begin
            logic [4:0] e;
            e = sb4.pop_front();
            if ({borrow4, diff4} !== e) begin
               errors++;
               $display("FAIL sb4_result got=%b_%b expected=%b_%b", borrow4, diff4, e[4], e[3:0]);
            end
            last4 = e;
         end
      end
   end

   // Scoreboard for the 8-bit instance
   always @(negedge clk) begin
      if (done8) begin
         checks++;
         if (sb8.size() == 0) begin
            errors++;
            $display("FAIL sb8_unexpected_done got=%b_%h expected=no_done", borrow8, diff8);
         end else begin
            logic [8:0] e;
            e = sb8.pop_front();
            if ({borrow8, diff8} !== e) begin
               errors++;
               $display("FAIL sb8_result got=%b_%h expected=%b_%h", borrow8, diff8, e[8], e[7:0]);
            end
         end
      end
   end

   // Drive a start on the current (negedge-aligned) cycle and queue its result
   task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
      sb4.push_back({1'b0, a} - {1'b0, b} - 5'(bin));
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
      sb8.push_back({1'b0, a} - {1'b0, b} - 9'(bin));
   endtask

   // Advance until done4, scrambling inputs after the accepting edge
   task automatic wait_done4(output int n);
      n = 0;
      do begin
         @(negedge clk);
         start4 = 1'b0;
         a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
         n++;
      end while (!done4 && n < 20);
      if (!done4) begin
         checks++; errors++;
         $display("FAIL done4_timeout got=no_done expected=done_within_20");
      end
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      do begin
         @(negedge clk);
         start8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         n++;
      end while (!done8 && n < 30);
      if (!done8) begin
         checks++; errors++;
         $display("FAIL done8_timeout got=no_done expected=done_within_30");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy4, done4, borrow4, diff4} !== 7'b0) begin
         errors++;
         $display("FAIL reset4 got=%b expected=0000000", {busy4, done4, borrow4, diff4});
      end
      checks++;
      if ({busy8, done8, borrow8, diff8} !== 11'b0) begin
         errors++;
         $display("FAIL reset8 got=%b expected=00000000000", {busy8, done8, borrow8, diff8});
      end
      rst_n = 1'b1;
      last4 = '0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [4:0] busy_seen, done_seen;
      issue4(4'b0101, 4'b0010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start4 = 1'b0;
         busy_seen[i] = busy4;
         done_seen[i] = done4;
      end
      checks++;
      if (busy_seen !== 5'b01111) begin
         errors++;
         $display("FAIL basic_busy_window got=%b expected=01111", busy_seen);
      end
      checks++;
      if (done_seen !== 5'b10000) begin
         errors++;
         $display("FAIL basic_done_timing got=%b expected=10000", done_seen);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_one_cycle got=%b expected=0", done4);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [3:0] va[3] = '{4'b0100, 4'b0101, 4'b0111};
      logic [3:0] vb[3] = '{4'b1001, 4'b0011, 4'b0110};
      logic       vc[3] = '{1'b1, 1'b1, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         issue4(va[i], vb[i], vc[i]);
         wait_done4(n);
         checks++;
         if (n !== 5) begin
            errors++;
            $display("FAIL b2b_latency[%0d] got=%0d expected=5", i, n);
         end
      end
   endtask

   task automatic test_wrap();
      int n;
      issue4(4'b0000, 4'b0000, 1'b1);
      wait_done4(n);
      issue4(4'b1111, 4'b1111, 1'b0);
      wait_done4(n);
      @(negedge clk);
   endtask

   task automatic test_ignore_busy();
      int n;
      logic [4:0] prev;
      prev = last4;
      issue4(4'b0101, 4'b0010, 1'b0);
      @(negedge clk); start4 = 1'b0;
      @(negedge clk); a4 = 4'b1111; b4 = 4'b0000; bin4 = 1'b0; start4 = 1'b1;
      checks++;
      if ({borrow4, diff4} !== prev) begin
         errors++;
         $display("FAIL hold_during_busy got=%b_%b expected=%b_%b", borrow4, diff4, prev[4], prev[3:0]);
      end
      @(negedge clk); start4 = 1'b0;
      @(negedge clk);
      checks++;
      if ({borrow4, diff4, done4} !== {prev, 1'b0}) begin
         errors++;
         $display("FAIL hold_late_busy got=%b_%b done=%b expected=%b_%b done=0",
                  borrow4, diff4, done4, prev[4], prev[3:0]);
      end
      wait_done4(n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL ignore_busy_latency got=%0d expected=1", n);
      end
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0) begin
         errors++;
         $display("FAIL ignore_busy_no_queue got=busy%b expected=busy0", busy4);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      logic any_done;
      a4 = 4'b1010; b4 = 4'b0001; bin4 = 1'b0; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy4, done4, borrow4, diff4} !== 7'b0) begin
         errors++;
         $display("FAIL abort_reset_state got=%b expected=0000000", {busy4, done4, borrow4, diff4});
      end
      rst_n = 1'b1;
      last4 = '0;
      any_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         any_done |= done4;
      end
      checks++;
      if (any_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done got=%b expected=0", any_done);
      end
      issue4(4'b1001, 4'b0011, 1'b0);
      wait_done4(n);
      @(negedge clk);
   endtask

   task automatic test_sweep4();
      int n;
      int bad_lat;
      logic [8:0] v;
      bad_lat = 0;
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         issue4(v[3:0], v[7:4], v[8]);
         wait_done4(n);
         if (n != 5) bad_lat++;
      end
      checks++;
      if (bad_lat !== 0) begin
         errors++;
         $display("FAIL sweep4_latency got=%0d_bad expected=0_bad", bad_lat);
      end
      @(negedge clk);
   endtask

   task automatic test_random8();
      int n;
      issue8(8'h00, 8'h00, 1'b1);
      wait_done8(n);
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL rand8_latency got=%0d expected=9", n);
      end
      for (int i = 0; i < 100; i++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom));
         wait_done8(n);
      end
      issue8(8'hFF, 8'hFF, 1'b0);
      wait_done8(n);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_ignore_busy();
      test_reset_abort();
      test_sweep4();
      test_random8();
      checks++;
      if (sb4.size() != 0 || sb8.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d/%0d expected=0/0", sb4.size(), sb8.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
